// File: rtl/cache_line_store.sv
// Direct-mapped cache way storage: line data plus tag/valid/dirty per index, with reset sweep,
// write-hit commit and multi-beat refill. Lookup latency 1 cycle; writes hold req_ready low for WR_COMMIT, refills for the whole FILL.
module cache_line_store #(
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_BYTES     = 4,
    parameter int INDEX_W        = 10,
    parameter int TAG_W          = 18,
    localparam int OFF_W         = $clog2(WORDS_PER_LINE),
    localparam int WORD_W        = 8 * WORD_BYTES,
    localparam int LINE_W        = WORD_W * WORDS_PER_LINE
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_busy,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [OFF_W-1:0]   req_word,
    input  logic [WORD_BYTES-1:0] req_be,
    input  logic [WORD_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic               rsp_dirty,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [LINE_W-1:0]  rsp_line,
    output logic [WORD_W-1:0]  rsp_word,
    input  logic               fill_start,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic               fill_beat,
    input  logic [WORD_W-1:0]  fill_data,
    output logic               fill_done
);

    localparam int DEPTH      = 2 ** INDEX_W;
    localparam int LINE_BYTES = LINE_W / 8;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR_COMMIT, S_FILL} state_t;

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   init_cnt_q, init_cnt_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [INDEX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;

    logic [INDEX_W-1:0]   req_idx_q;
    logic [OFF_W-1:0]     req_word_q;
    logic [WORD_BYTES-1:0] req_be_q;
    logic [WORD_W-1:0]    req_wdata_q;

    logic                 rsp_valid_q, rsp_hit_q, rsp_dirty_q, fill_done_q;
    logic [TAG_W-1:0]     rsp_tag_q;
    logic [LINE_W-1:0]    rsp_line_q;

    logic [LINE_W-1:0]    data_mem [DEPTH];
    logic [TAG_W-1:0]     tag_mem  [DEPTH];
    logic [DEPTH-1:0]     valid_mem;
    logic [DEPTH-1:0]     dirty_mem;

    logic                 req_fire;
    logic                 mem_we;
    logic [INDEX_W-1:0]   mem_idx;
    logic [LINE_W-1:0]    mem_line;
    logic [LINE_BYTES-1:0] mem_mask;
    logic                 flag_we, flag_valid, flag_dirty, tag_we, fill_last;
    logic [INDEX_W-1:0]   flag_idx;

    assign init_busy = rst || (state_q == S_INIT);
    assign req_ready = !rst && (state_q == S_IDLE) && !fill_start;
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        beat_d     = beat_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        mem_we     = 1'b0;
        mem_idx    = fill_idx_q;
        mem_line   = '0;
        mem_mask   = '0;
        flag_we    = 1'b0;
        flag_idx   = init_cnt_q;
        flag_valid = 1'b0;
        flag_dirty = 1'b0;
        tag_we     = 1'b0;
        fill_last  = 1'b0;
        case (state_q)
            S_INIT: begin
                flag_we    = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (fill_start) begin
                    fill_idx_d = fill_index;
                    fill_tag_d = fill_tag;
                    beat_d     = '0;
                    state_d    = S_FILL;
                end else if (req_valid && req_wr) begin
                    state_d = S_WR_COMMIT;
                end
            end
            S_WR_COMMIT: begin
                // Only a hit may modify the line; a miss leaves the victim intact for write-back.
                if (rsp_hit_q && (req_be_q != '0)) begin
                    mem_we     = 1'b1;
                    mem_idx    = req_idx_q;
                    mem_line   = {WORDS_PER_LINE{req_wdata_q}};
                    mem_mask   = LINE_BYTES'(req_be_q) << (32'(req_word_q) * WORD_BYTES);
                    flag_we    = 1'b1;
                    flag_idx   = req_idx_q;
                    flag_valid = 1'b1;
                    flag_dirty = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_FILL: begin
                if (fill_beat) begin
                    mem_we   = 1'b1;
                    mem_idx  = fill_idx_q;
                    mem_line = {WORDS_PER_LINE{fill_data}};
                    mem_mask = LINE_BYTES'({WORD_BYTES{1'b1}}) << (32'(beat_q) * WORD_BYTES);
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == '1) begin
                        fill_last  = 1'b1;
                        flag_we    = 1'b1;
                        flag_idx   = fill_idx_q;
                        flag_valid = 1'b1;
                        tag_we     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            beat_q     <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            beat_q     <= beat_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_dirty_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_line_q  <= '0;
            fill_done_q <= 1'b0;
            req_idx_q   <= '0;
            req_word_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
        end else begin
            rsp_valid_q <= req_fire;
            fill_done_q <= fill_last;
            if (req_fire) begin
                rsp_hit_q   <= valid_mem[req_index] && (tag_mem[req_index] == req_tag);
                rsp_dirty_q <= dirty_mem[req_index];
                rsp_tag_q   <= tag_mem[req_index];
                rsp_line_q  <= data_mem[req_index];
                req_idx_q   <= req_index;
                req_word_q  <= req_word;
                req_be_q    <= req_be;
                req_wdata_q <= req_wdata;
            end
        end
    end

    // Storage arrays carry no reset; validity comes from the INIT sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (mem_we && mem_mask[b]) data_mem[mem_idx][b*8 +: 8] <= mem_line[b*8 +: 8];
            end
            if (flag_we) begin
                valid_mem[flag_idx] <= flag_valid;
                dirty_mem[flag_idx] <= flag_dirty;
            end
            if (tag_we) tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_dirty = rsp_dirty_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_line  = rsp_line_q;
    assign rsp_word  = rsp_line_q[32'(req_word_q) * WORD_W +: WORD_W];
    assign fill_done = fill_done_q;

endmodule

// File: doc/cache_line_store.md
Name: cache_line_store

Overview:
- Parametrised direct-mapped cache way storage.
- Holds data lines plus tag/valid/dirty per index.
- Adds features not in the earlier single-config block:
  - generic line/word/byte geometry;
  - reset-time invalidation sweep;
  - tag compare with write-hit commit;
  - multi-beat line refill engine.
- Sits between the cache controller FSM and the memory refill path.

Parameters:
WORDS_PER_LINE, 4, words per line; power of 2, >=2
WORD_BYTES, 4, bytes per word; power of 2
INDEX_W, 10, index width; depth = 2**INDEX_W lines
TAG_W, 18, tag width
(derived) OFF_W = log2(WORDS_PER_LINE); WORD_W = 8*WORD_BYTES; LINE_W = WORD_W*WORDS_PER_LINE

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
init_busy  out  1  invalidation sweep in progress
req_valid  in  1  CPU lookup request
req_ready  out  1  request accepted when req_valid && req_ready
req_wr  in  1  1 = write, 0 = read
req_index  in  INDEX_W  line index
req_tag  in  TAG_W  compare tag
req_word  in  OFF_W  word offset in line
req_be  in  WORD_BYTES  byte enables (write only)
req_wdata  in  WORD_W  write data
rsp_valid  out  1  lookup result valid (1 cycle after accept)
rsp_hit  out  1  stored valid && stored tag == req_tag
rsp_dirty  out  1  stored dirty bit (before this access)
rsp_tag  out  TAG_W  stored tag (victim address for write-back)
rsp_line  out  LINE_W  full stored line (victim data / read data)
rsp_word  out  WORD_W  word req_word of rsp_line
fill_start  in  1  begin refill of fill_index
fill_index  in  INDEX_W  refill index
fill_tag  in  TAG_W  refill tag
fill_beat  in  1  one refill word on fill_data
fill_data  in  WORD_W  refill word; beats arrive in order, word 0 first
fill_done  out  1  one-cycle pulse, refill committed

Behaviour:
- Interface: one clock (clk); rst synchronous, active-high.

Reset (rst high in any state, including mid-sweep or mid-fill):
- Next state is INIT with sweep counter = 0.
- Outputs: rsp_valid = 0, fill_done = 0, req_ready = 0, init_busy = 1.
- rsp_hit, rsp_dirty, rsp_tag, rsp_line, rsp_word all = 0.
- A partial fill is abandoned; its line keeps whatever flags the sweep writes.

States: INIT, IDLE, WR_COMMIT, FILL.

INIT:
- Each cycle writes valid = 0, dirty = 0 at the counter index, then increments the counter.
- After index 2**INDEX_W-1: next state IDLE, init_busy = 0.
- Sweep lasts exactly 2**INDEX_W cycles after rst deasserts.
- Data RAM is not cleared.

IDLE:
- req_ready = !fill_start (combinational).
- fill_start has priority over req_valid in the same cycle.
- fill_start: latch fill_index/fill_tag, beat counter = 0, next state FILL.
- Accepted read: registered RAM read.
  - Next cycle: rsp_valid = 1 with rsp_* from the stored entry.
  - No state change; back-to-back reads allowed, one per cycle.
- Accepted write: RAM read as for a read, next state WR_COMMIT.

WR_COMMIT (1 cycle, req_ready = 0):
- rsp_valid = 1, rsp_* reflect pre-write contents.
- If rsp_hit && req_be != 0:
  - Write enabled bytes of word req_word (byte mask = req_be << (req_word*WORD_BYTES)).
  - Set dirty = 1; valid and tag unchanged.
- Miss or req_be == 0: no storage change.
- Next state IDLE.
- Write latency: 2 cycles; a read of the same index issued next is accepted the cycle after WR_COMMIT and returns the new bytes.

FILL (req_ready = 0):
- Each fill_beat writes all bytes of word [beat counter] at the latched index, then increments the counter.
- Cycles without fill_beat stall the fill.
- On the final beat (counter == WORDS_PER_LINE-1) the same cycle writes tag = fill_tag, valid = 1, dirty = 0.
- Cycle after the final beat: fill_done = 1, next state IDLE.
- fill_start outside IDLE is ignored.
- fill_beat outside FILL is ignored.

rsp_valid is a single-cycle pulse per accepted request.

Test Plan:
- Sweep: rst 1 cycle, INDEX_W = 4 → init_busy high for exactly 16 cycles; then read any index → rsp_hit = 0, rsp_dirty = 0.
- Refill then read hit: fill index 5, tag 0x2A, beats 0x11111111..0x44444444 → fill_done one cycle after beat 4; read index 5, tag 0x2A, word 2 → rsp_hit = 1, rsp_word = 0x33333333, rsp_dirty = 0.
- Byte write hit:
  - Write index 5, tag 0x2A, word 1, be = 4'b0100, data 0x00AB0000.
  - Next read word 1 → 0x22AB2222, rsp_dirty = 1.
  - req_ready low during WR_COMMIT.
- Write miss / victim: write index 5, tag 0x2B → rsp_hit = 0, rsp_tag = 0x2A, rsp_dirty = 1, line unchanged.
- Priority and stall: fill_start and req_valid in the same cycle → req_ready = 0, fill taken. Gaps between beats → fill_done still after the 4th beat only.
- Reset mid-fill: rst after beat 2 → init_busy = 1; after sweep, read of that index → rsp_hit = 0; no fill_done pulse.
